ercm8_sweep_ctrl: RTL and testbench

Sequencing controller for the 8x8 approximate multiplier ERCM8_V2_1 (dat_in_a, dat_in_b, mask[6:0], dat_o[15:0]).
- Sweeps a range of mask settings.
- For each mask, drives 2^SAMPLES_LOG2 pseudo-random operand pairs and waits a programmable settle time for the multiplier output.
- Compares each captured product against the exact product and accumulates error metrics.
- Reports one result record per mask over a valid/ready interface.
- Replaces the per-sample software loop for on-chip error characterisation.

---
 rtl/ercm8_sweep_ctrl.sv | 137 +++++++++++++
 tb/tb_ercm8_sweep_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ercm8_sweep_ctrl.sv
// Sweep controller for the ERCM8 approximate multiplier: drives pseudo-random operand
// pairs for each mask in a range and reports error statistics per mask.
module ercm8_sweep_ctrl #(
  parameter int          SETTLE_CYC   = 4,
  parameter int          SAMPLES_LOG2 = 10,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [6:0]                 mask_first,
  input  logic [6:0]                 mask_last,
  output logic                       busy,
  output logic [7:0]                 mul_a,
  output logic [7:0]                 mul_b,
  output logic [6:0]                 mul_mask,
  input  logic [15:0]                mul_p,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [6:0]                 res_mask,
  output logic [SAMPLES_LOG2:0]      res_err_cnt,
  output logic [SAMPLES_LOG2+15:0]   res_sum_ed,
  output logic [15:0]                res_max_ed,
  output logic                       done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  logic [2:0]                  state;
  logic [15:0]                 lfsr;
  logic [6:0]                  mask_r;
  logic [6:0]                  mask_last_r;
  logic [SAMPLES_LOG2-1:0]     smp_cnt;
  logic [SW-1:0]               settle_cnt;
  logic [SAMPLES_LOG2:0]       err_cnt;
  logic [SAMPLES_LOG2+15:0]    sum_ed;
  logic [15:0]                 max_ed;

  logic [15:0] exact;
  logic [15:0] ed;
  logic [15:0] lfsr_next;

  assign exact     = 16'(mul_a) * 16'(mul_b);
  assign ed        = (exact >= mul_p) ? (exact - mul_p) : (mul_p - exact);
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Handshake: a record is offered while res_valid is high and its fields stay
  // frozen until the cycle where res_valid && res_ready, which consumes it.
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign res_valid   = (state == S_REPORT);
  assign res_mask    = mask_r;
  assign res_err_cnt = err_cnt;
  assign res_sum_ed  = sum_ed;
  assign res_max_ed  = max_ed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lfsr        <= SEED;
      mask_r      <= 7'd0;
      mask_last_r <= 7'd0;
      smp_cnt     <= '0;
      settle_cnt  <= '0;
      err_cnt     <= '0;
      sum_ed      <= '0;
      max_ed      <= 16'd0;
      mul_a       <= 8'd0;
      mul_b       <= 8'd0;
      mul_mask    <= 7'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_r      <= mask_first;
            mask_last_r <= mask_last;
            lfsr        <= SEED;
            smp_cnt     <= '0;
            err_cnt     <= '0;
            sum_ed      <= '0;
            max_ed      <= 16'd0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          mul_a      <= lfsr[15:8];
          mul_b      <= lfsr[7:0];
          mul_mask   <= mask_r;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          err_cnt <= err_cnt + {{SAMPLES_LOG2{1'b0}}, (ed != 16'd0)};
          sum_ed  <= sum_ed + {{SAMPLES_LOG2{1'b0}}, ed};
          if (ed > max_ed) max_ed <= ed;
          lfsr    <= lfsr_next;
          smp_cnt <= smp_cnt + 1'b1;
          // All-ones count means this was the final sample of the mask.
          state   <= (&smp_cnt) ? S_REPORT : S_LOAD;
        end
        S_REPORT: begin
          if (res_ready) begin
            if (mask_r == mask_last_r) begin
              state <= S_DONE;
            end else begin
              mask_r  <= mask_r + 7'd1;
              lfsr    <= SEED;
              smp_cnt <= '0;
              err_cnt <= '0;
              sum_ed  <= '0;
              max_ed  <= 16'd0;
              state   <= S_LOAD;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ercm8_sweep_ctrl.sv
// Directed bench for ercm8_sweep_ctrl with four samples per mask and a behavioural
// multiplier whose error pattern is selected per test.
module tb_ercm8_sweep_ctrl;

  localparam int SL = 2;
  localparam int SC = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [6:0]        mask_first = 7'd0;
  logic [6:0]        mask_last = 7'd0;
  logic              busy;
  logic [7:0]        mul_a, mul_b;
  logic [6:0]        mul_mask;
  logic [15:0]       mul_p;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [6:0]        res_mask;
  logic [SL:0]       res_err_cnt;
  logic [SL+15:0]    res_sum_ed;
  logic [15:0]       res_max_ed;
  logic              done;

  int checks = 0;
  int errors = 0;
  int err_mode = 0;

  logic [7:0] a_tab [4] = '{8'hAC, 8'h59, 8'hB3, 8'h67};
  logic [7:0] b_tab [4] = '{8'hE1, 8'hC3, 8'h87, 8'h0F};

  ercm8_sweep_ctrl #(.SETTLE_CYC(SC), .SAMPLES_LOG2(SL), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mask_first(mask_first), .mask_last(mask_last),
    .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_mask(res_mask),
    .res_err_cnt(res_err_cnt), .res_sum_ed(res_sum_ed), .res_max_ed(res_max_ed), .done(done)
  );

  always #5 clk = ~clk;

  // Mode 0: exact, mode 1: LSB flipped (ed=1), mode 2: product minus mask (ed=mask).
  always_comb begin
    mul_p = 16'(mul_a) * 16'(mul_b);
    case (err_mode)
      1:       mul_p = mul_p ^ 16'h0001;
      2:       mul_p = mul_p - {9'd0, mul_mask};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge just before the LOAD-entry edge; returns at the negedge where
  // res_valid is first seen. start pulses issued by the caller drop after the first edge.
  task automatic wait_valid(input string tag, input bit chk_ops, input int pulse_at,
                            input logic [6:0] pulse_mask);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (res_valid) break;
      if (n > 200) begin
        check({tag, "_timeout"}, 32'd0, 32'd1);
        return;
      end
      if (n == pulse_at) begin
        start = 1'b1; mask_first = pulse_mask; mask_last = pulse_mask;
      end
      if (n == pulse_at + 1) start = 1'b0;
      if (n < 24) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (chk_ops && (n % 6 == 3) && (n < 24)) begin
        check({tag, "_mul_a"}, {24'd0, mul_a}, {24'd0, a_tab[n / 6]});
        check({tag, "_mul_b"}, {24'd0, mul_b}, {24'd0, b_tab[n / 6]});
      end
    end
    check({tag, "_latency"}, n, 32'd25);
  endtask

  task automatic expect_record(input string tag, input logic [6:0] m, input int ec,
                               input int se, input int mx);
    check({tag, "_mask"},    {25'd0, res_mask}, {25'd0, m});
    check({tag, "_err_cnt"}, 32'(res_err_cnt), ec);
    check({tag, "_sum_ed"},  32'(res_sum_ed), se);
    check({tag, "_max_ed"},  {16'd0, res_max_ed}, mx);
  endtask

  task automatic expect_done(input string tag);
    @(negedge clk);
    check({tag, "_done_hi"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    check({tag, "_valid_lo"}, {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_done_lo"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic launch(input logic [6:0] mf, input logic [6:0] ml);
    mask_first = mf; mask_last = ml; start = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_valid", {31'd0, res_valid}, 0);
    check("rst_ops", {16'd0, mul_a, mul_b}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact multiplier, single mask
    err_mode = 0;
    launch(7'd5, 7'd5);
    wait_valid("exact", 1'b1, 0, 7'd0);
    expect_record("exact", 7'd5, 0, 0, 0);
    expect_done("exact");

    // LSB-flip error, single mask
    err_mode = 1;
    launch(7'd5, 7'd5);
    wait_valid("lsb", 1'b1, 0, 7'd0);
    expect_record("lsb", 7'd5, 4, 4, 1);
    expect_done("lsb");

    // Backpressure on first of two records
    res_ready = 1'b0;
    launch(7'd5, 7'd6);
    wait_valid("stall", 1'b0, 0, 7'd0);
    for (int i = 0; i < 10; i++) begin
      expect_record("stall_hold", 7'd5, 4, 4, 1);
      check("stall_valid", {31'd0, res_valid}, 1);
      check("stall_ops", {16'd0, mul_a, mul_b}, 32'h670F);
      check("stall_done", {31'd0, done}, 0);
      @(negedge clk);
    end
    expect_record("stall_last", 7'd5, 4, 4, 1);
    res_ready = 1'b1;
    wait_valid("stall_next", 1'b1, 0, 7'd0);
    expect_record("stall_next", 7'd6, 4, 4, 1);
    expect_done("stall");

    // Wrapping sweep, error equal to mask
    err_mode = 2;
    launch(7'd126, 7'd1);
    for (int r = 0; r < 4; r++) begin
      logic [6:0] m;
      m = 7'(126 + r);
      wait_valid("wrap", 1'b1, 0, 7'd0);
      expect_record("wrap", m, (m != 0) ? 4 : 0, 4 * int'(m), int'(m));
      check("wrap_mul_mask", {25'd0, mul_mask}, {25'd0, m});
      check("wrap_last_ops", {16'd0, mul_a, mul_b}, 32'h670F);
    end
    expect_done("wrap");
    repeat (3) begin
      @(negedge clk);
      check("wrap_no_extra_done", {31'd0, done}, 0);
    end

    // start while busy must be ignored
    err_mode = 0;
    launch(7'd10, 7'd11);
    wait_valid("ign0", 1'b0, 5, 7'd40);
    expect_record("ign0", 7'd10, 0, 0, 0);
    wait_valid("ign1", 1'b1, 0, 7'd0);
    expect_record("ign1", 7'd11, 0, 0, 0);
    expect_done("ign");

    // Asynchronous reset mid-SETTLE, then a fresh sweep
    launch(7'd3, 7'd3);
    repeat (4) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_ops", {9'd0, mul_a, mul_b, mul_mask}, 0);
    check("arst_res", {25'd0, res_mask} | 32'(res_err_cnt) | 32'(res_sum_ed) | {16'd0, res_max_ed}, 0);
    check("arst_valid_done", {30'd0, res_valid, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", {31'd0, busy}, 0);
    launch(7'd3, 7'd3);
    wait_valid("arst_fresh", 1'b1, 0, 7'd0);
    expect_record("arst_fresh", 7'd3, 0, 0, 0);
    expect_done("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
